// File: rtl/memory_bus_controller_if.sv
// memory_bus_controller_if
// External memory bus between the controller (master) and a memory slave.
//   bus_valid        master -> slave  transaction presented
//   bus_write        master -> slave  1 = write, 0 = read
//   bus_address      master -> slave  word-aligned byte address
//   bus_byte_enable  master -> slave  per-lane strobes
//   bus_write_data   master -> slave  lane-replicated store data
//   bus_ready        slave -> master  slave accepts/completes this cycle
//   bus_read_data    slave -> master  load data, valid with bus_ready on reads
interface memory_bus_controller_if;
    logic        bus_valid;
    logic        bus_write;
    logic [31:0] bus_address;
    logic [3:0]  bus_byte_enable;
    logic [31:0] bus_write_data;
    logic        bus_ready;
    logic [31:0] bus_read_data;

    modport master (
        output bus_valid,
        output bus_write,
        output bus_address,
        output bus_byte_enable,
        output bus_write_data,
        input  bus_ready,
        input  bus_read_data
    );

    modport slave (
        input  bus_valid,
        input  bus_write,
        input  bus_address,
        input  bus_byte_enable,
        input  bus_write_data,
        output bus_ready,
        output bus_read_data
    );
endinterface

// File: rtl/memory_bus_controller.sv
// memory_bus_controller
// Turns the core's per-phase pad strobes into one registered valid/ready
// transaction on the external memory bus, and returns aligned, extended load
// data. stall freezes the phase sequencer while a transaction is outstanding.
// Ports:
//   clock, reset        system clock, asynchronous active-low reset
//   pad_read/pad_write  core request strobes (write wins when both are high)
//   pad_data_size       00 byte, 01 half, 1x word
//   data_type           load funct3 (LB/LH/LW/LBU/LHU, others act as LW)
//   address, write_data byte address and low-aligned store data
//   read_data           aligned, extended load result (held between loads)
//   stall               core must hold its phase
//   misaligned          one-cycle pulse: request rejected, no bus cycle
//   bus_timeout         one-cycle pulse: transaction aborted
//   bus                 memory bus, master side
module memory_bus_controller #(
    parameter int          TIMEOUT_CYCLES  = 255,
    parameter logic [31:0] RESET_READ_DATA = 32'h0000_0000
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           pad_read,
    input  logic                           pad_write,
    input  logic [1:0]                     pad_data_size,
    input  logic [2:0]                     data_type,
    input  logic [31:0]                    address,
    input  logic [31:0]                    write_data,
    output logic [31:0]                    read_data,
    output logic                           stall,
    output logic                           misaligned,
    output logic                           bus_timeout,
    memory_bus_controller_if.master        bus
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Byte accesses are always aligned; halves need an even address, words
    // (including the 2'b10 encoding) need a word-aligned address.
    function automatic logic aligned_f(input logic [1:0] size, input logic [1:0] off);
        logic ok;
        case (size)
            2'b00:   ok = 1'b1;
            2'b01:   ok = (off[0] == 1'b0);
            default: ok = (off == 2'b00);
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_enable_f(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data arrives low-aligned; copying it into every lane lets the
    // byte strobes alone pick the destination.
    function automatic logic [31:0] write_lanes_f(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] lanes;
        case (size)
            2'b00:   lanes = {4{data[7:0]}};
            2'b01:   lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] load_extend_f(input logic [2:0]  dtype,
                                                  input logic [1:0]  off,
                                                  input logic [31:0] word);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] result;
        lane_b = word[{off, 3'b000} +: 8];
        lane_h = off[1] ? word[31:16] : word[15:0];
        case (dtype)
            3'b000:  result = {{24{lane_b[7]}}, lane_b};
            3'b001:  result = {{16{lane_h[15]}}, lane_h};
            3'b100:  result = {24'h00_0000, lane_b};
            3'b101:  result = {16'h0000, lane_h};
            default: result = word;
        endcase
        return result;
    endfunction

    state_t            state_r;
    logic [CNT_W-1:0]  count_r;
    logic              bus_valid_r;
    logic              bus_write_r;
    logic [31:0]       bus_address_r;
    logic [3:0]        bus_byte_enable_r;
    logic [31:0]       bus_write_data_r;
    logic [2:0]        data_type_r;
    logic [1:0]        offset_r;
    logic              stall_r;
    logic              misaligned_r;
    logic              bus_timeout_r;
    logic [31:0]       read_data_r;

    logic              request_s;
    logic              aligned_s;
    logic              accept_s;
    logic              reject_s;

    // Request decode for the IDLE cycle; pads are ignored in every other state.
    always_comb begin
        request_s = pad_read | pad_write;
        aligned_s = aligned_f(pad_data_size, address[1:0]);
        accept_s  = 1'b0;
        reject_s  = 1'b0;
        if (state_r == IDLE) begin
            accept_s = request_s & aligned_s;
            reject_s = request_s & ~aligned_s;
        end else begin
            accept_s = 1'b0;
            reject_s = 1'b0;
        end
    end

    // Stall must rise in the very cycle an aligned request is seen so the core
    // never advances past it; gating with reset drops it the moment reset hits.
    assign stall       = reset & (stall_r | accept_s);
    assign misaligned  = misaligned_r;
    assign bus_timeout = bus_timeout_r;
    assign read_data   = read_data_r;

    assign bus.bus_valid       = bus_valid_r;
    assign bus.bus_write       = bus_write_r;
    assign bus.bus_address     = bus_address_r;
    assign bus.bus_byte_enable = bus_byte_enable_r;
    assign bus.bus_write_data  = bus_write_data_r;

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r           <= IDLE;
            count_r           <= CNT_ZERO;
            bus_valid_r       <= 1'b0;
            bus_write_r       <= 1'b0;
            bus_address_r     <= 32'h0000_0000;
            bus_byte_enable_r <= 4'b0000;
            bus_write_data_r  <= 32'h0000_0000;
            data_type_r       <= 3'b000;
            offset_r          <= 2'b00;
            stall_r           <= 1'b0;
            misaligned_r      <= 1'b0;
            bus_timeout_r     <= 1'b0;
            read_data_r       <= RESET_READ_DATA;
        end else begin
            misaligned_r  <= 1'b0;
            bus_timeout_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        bus_valid_r       <= 1'b1;
                        bus_write_r       <= pad_write;
                        bus_address_r     <= {address[31:2], 2'b00};
                        bus_byte_enable_r <= byte_enable_f(pad_data_size, address[1:0]);
                        bus_write_data_r  <= write_lanes_f(pad_data_size, write_data);
                        data_type_r       <= data_type;
                        offset_r          <= address[1:0];
                        stall_r           <= 1'b1;
                        count_r           <= CNT_ZERO;
                        state_r           <= REQUEST;
                    end else if (reject_s) begin
                        misaligned_r <= 1'b1;
                    end
                end
                REQUEST: begin
                    // A handshake on the final allowed cycle still completes.
                    if (bus.bus_ready) begin
                        if (!bus_write_r) begin
                            read_data_r <= load_extend_f(data_type_r, offset_r, bus.bus_read_data);
                        end
                        bus_valid_r <= 1'b0;
                        stall_r     <= 1'b0;
                        count_r     <= CNT_ZERO;
                        state_r     <= DONE;
                    end else if (count_r == CNT_LAST) begin
                        if (!bus_write_r) begin
                            read_data_r <= 32'h0000_0000;
                        end
                        bus_valid_r   <= 1'b0;
                        stall_r       <= 1'b0;
                        bus_timeout_r <= 1'b1;
                        count_r       <= CNT_ZERO;
                        state_r       <= DONE;
                    end else begin
                        count_r <= count_r + CNT_ONE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    bus_valid_r <= 1'b0;
                    stall_r     <= 1'b0;
                    count_r     <= CNT_ZERO;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_bus_controller.sv
// tb_memory_bus_controller
// Directed bench: each request fills a per-cycle timeline of expected outputs,
// and a negedge compare process checks the DUT against it every cycle.
module tb_memory_bus_controller;

    localparam int          TO     = 4;
    localparam logic [31:0] RST_RD = 32'h5A5A_1234;
    localparam int          N      = 600;

    logic        clock;
    logic        reset;
    logic        pad_read;
    logic        pad_write;
    logic [1:0]  pad_data_size;
    logic [2:0]  data_type;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        stall;
    logic        misaligned;
    logic        bus_timeout;

    memory_bus_controller_if bus_if();

    memory_bus_controller #(
        .TIMEOUT_CYCLES  (TO),
        .RESET_READ_DATA (RST_RD)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pad_read      (pad_read),
        .pad_write     (pad_write),
        .pad_data_size (pad_data_size),
        .data_type     (data_type),
        .address       (address),
        .write_data    (write_data),
        .read_data     (read_data),
        .stall         (stall),
        .misaligned    (misaligned),
        .bus_timeout   (bus_timeout),
        .bus           (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Expected per-cycle timeline
    logic        exp_stall [N];
    logic        exp_valid [N];
    logic        exp_wr    [N];
    logic        exp_mis   [N];
    logic        exp_to    [N];
    logic [31:0] exp_addr  [N];
    logic [31:0] exp_wd    [N];
    logic [31:0] exp_rd    [N];
    logic [3:0]  exp_be    [N];

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Event counters and last bus fields seen, for literal end-of-transaction checks
    int          stall_cnt = 0;
    int          valid_cnt = 0;
    int          to_cnt    = 0;
    int          mis_cnt   = 0;
    logic [31:0] last_addr = 32'h0;
    logic [31:0] last_wd   = 32'h0;
    logic [3:0]  last_be   = 4'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic model_aligned(input logic [1:0] size, input logic [1:0] off);
        if (size == 2'b00) return 1'b1;
        if (size == 2'b01) return (off % 2) == 0;
        return off == 2'b00;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [1:0] off);
        if (size == 2'b00) return 4'(1 << off);
        if (size == 2'b01) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wd(input logic [1:0] size, input logic [31:0] wd);
        if (size == 2'b00) return (wd & 32'h0000_00FF) * 32'h0101_0101;
        if (size == 2'b01) return (wd & 32'h0000_FFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] dt, input logic [1:0] off, input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * off)) & 32'h0000_00FF;
        h = (w >> (16 * (off / 2))) & 32'h0000_FFFF;
        case (dt)
            3'b000:  return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    // Per-cycle compare against the expected timeline
    always @(negedge clock) begin
        if (cmp_en && cyc < N) begin
            chk("stall",       {31'b0, stall},              {31'b0, exp_stall[cyc]});
            chk("bus_valid",   {31'b0, bus_if.bus_valid},   {31'b0, exp_valid[cyc]});
            chk("misaligned",  {31'b0, misaligned},         {31'b0, exp_mis[cyc]});
            chk("bus_timeout", {31'b0, bus_timeout},        {31'b0, exp_to[cyc]});
            chk("read_data",   read_data,                   exp_rd[cyc]);
            if (exp_valid[cyc]) begin
                chk("bus_write",       {31'b0, bus_if.bus_write},      {31'b0, exp_wr[cyc]});
                chk("bus_address",     bus_if.bus_address,             exp_addr[cyc]);
                chk("bus_byte_enable", {28'b0, bus_if.bus_byte_enable}, {28'b0, exp_be[cyc]});
                chk("bus_write_data",  bus_if.bus_write_data,          exp_wd[cyc]);
            end
        end
    end

    // Event monitor
    always @(negedge clock) begin
        if (stall)            stall_cnt <= stall_cnt + 1;
        if (bus_if.bus_valid) valid_cnt <= valid_cnt + 1;
        if (bus_timeout)      to_cnt    <= to_cnt + 1;
        if (misaligned)       mis_cnt   <= mis_cnt + 1;
        if (bus_if.bus_valid) begin
            last_addr <= bus_if.bus_address;
            last_wd   <= bus_if.bus_write_data;
            last_be   <= bus_if.bus_byte_enable;
        end
    end

    task automatic pads_idle();
        pad_read  = 1'b0;
        pad_write = 1'b0;
    endtask

    // Issue one request at the current cycle (called #1 after a posedge in IDLE).
    // ready_at: REQUEST cycle (1-based) in which bus_ready is raised; 0 = never.
    task automatic do_req(input logic wr, input logic rd_also, input logic [1:0] size,
                          input logic [2:0] dt, input logic [31:0] addr, input logic [31:0] wd,
                          input int ready_at, input logic [31:0] rdata, input bit pad_in_done);
        int          c;
        int          n;
        int          d;
        logic        hs;
        logic [31:0] newrd;
        c = cyc;
        pad_write     = wr;
        pad_read      = ~wr | rd_also;
        pad_data_size = size;
        data_type     = dt;
        address       = addr;
        write_data    = wd;
        if (c + TO + 3 >= N) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", c, N - TO - 3);
            $fatal(1);
        end
        if (!model_aligned(size, addr[1:0])) begin
            exp_mis[c + 1] = 1'b1;
            @(posedge clock); #1;
            pads_idle();
            @(posedge clock); #1;
            return;
        end
        hs = (ready_at >= 1) && (ready_at <= TO);
        n  = hs ? ready_at : TO;
        d  = c + n + 1;
        exp_stall[c] = 1'b1;
        for (int i = 1; i <= n; i++) begin
            exp_stall[c + i] = 1'b1;
            exp_valid[c + i] = 1'b1;
            exp_wr[c + i]    = wr;
            exp_addr[c + i]  = addr & 32'hFFFF_FFFC;
            exp_be[c + i]    = model_be(size, addr[1:0]);
            exp_wd[c + i]    = model_wd(size, wd);
        end
        exp_to[d] = ~hs;
        if (!wr) begin
            newrd = hs ? model_load(dt, addr[1:0], rdata) : 32'h0;
            for (int k = d; k < N; k++) exp_rd[k] = newrd;
        end
        for (int i = 1; i <= n; i++) begin
            @(posedge clock); #1;
            pads_idle();
            bus_if.bus_ready     = (i == ready_at);
            bus_if.bus_read_data = (i == ready_at) ? rdata : ~rdata;
        end
        @(posedge clock); #1;
        bus_if.bus_ready = 1'b0;
        if (pad_in_done) begin
            pad_read      = 1'b1;
            pad_data_size = 2'b11;
            address       = 32'h0000_0600;
        end
        @(posedge clock); #1;
        pads_idle();
    endtask

    int s0;
    int v0;
    int t0;
    int m0;
    int rc;

    initial begin
        for (int k = 0; k < N; k++) begin
            exp_stall[k] = 1'b0; exp_valid[k] = 1'b0; exp_wr[k] = 1'b0;
            exp_mis[k]   = 1'b0; exp_to[k]    = 1'b0; exp_addr[k] = 32'h0;
            exp_wd[k]    = 32'h0; exp_be[k]   = 4'h0; exp_rd[k]   = RST_RD;
        end
        reset = 1'b1;
        pads_idle();
        pad_data_size        = 2'b00;
        data_type            = 3'b000;
        address              = 32'h0;
        write_data           = 32'h0;
        bus_if.bus_ready     = 1'b0;
        bus_if.bus_read_data = 32'h0;
        cmp_en = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        chk("reset_read_data", read_data, 32'h5A5A_1234);

        // Aligned LW, ready on 2nd REQUEST cycle
        s0 = stall_cnt;
        do_req(1'b0, 1'b0, 2'b11, 3'b010, 32'h0000_0100, 32'h0, 2, 32'hDEAD_BEEF, 1'b0);
        chk("lw_stall_cycles", stall_cnt - s0, 32'd3);
        chk("lw_read_data", read_data, 32'hDEAD_BEEF);
        chk("lw_be", {28'b0, last_be}, 32'h0000_000F);
        chk("lw_addr", last_addr, 32'h0000_0100);

        // LB / LBU at byte 3
        do_req(1'b0, 1'b0, 2'b00, 3'b000, 32'h0000_0103, 32'h0, 1, 32'h80FF_FFFF, 1'b0);
        chk("lb_read_data", read_data, 32'hFFFF_FF80);
        chk("lb_be", {28'b0, last_be}, 32'h0000_0008);
        do_req(1'b0, 1'b0, 2'b00, 3'b100, 32'h0000_0103, 32'h0, 1, 32'h80FF_FFFF, 1'b0);
        chk("lbu_read_data", read_data, 32'h0000_0080);

        // SH at 0x202
        do_req(1'b1, 1'b0, 2'b01, 3'b000, 32'h0000_0202, 32'h1234_ABCD, 1, 32'h0, 1'b0);
        chk("sh_wdata", last_wd, 32'hABCD_ABCD);
        chk("sh_be", {28'b0, last_be}, 32'h0000_000C);
        chk("sh_addr", last_addr, 32'h0000_0200);
        chk("sh_read_data_held", read_data, 32'h0000_0080);

        // Misaligned LW and SH
        s0 = stall_cnt; v0 = valid_cnt; m0 = mis_cnt;
        do_req(1'b0, 1'b0, 2'b11, 3'b010, 32'h0000_0101, 32'h0, 1, 32'h0, 1'b0);
        do_req(1'b1, 1'b0, 2'b01, 3'b000, 32'h0000_0203, 32'h5555_6666, 1, 32'h0, 1'b0);
        chk("mis_pulses", mis_cnt - m0, 32'd2);
        chk("mis_valid", valid_cnt - v0, 32'd0);
        chk("mis_stall", stall_cnt - s0, 32'd0);

        // Read timeout
        v0 = valid_cnt; t0 = to_cnt;
        do_req(1'b0, 1'b0, 2'b11, 3'b010, 32'h0000_0040, 32'h0, 0, 32'h7777_7777, 1'b0);
        chk("to_valid_cycles", valid_cnt - v0, 32'd4);
        chk("to_pulses", to_cnt - t0, 32'd1);
        chk("to_read_data", read_data, 32'h0000_0000);

        // Halves: ready on the last allowed cycle still completes
        t0 = to_cnt;
        do_req(1'b0, 1'b0, 2'b01, 3'b001, 32'h0000_0102, 32'h0, TO, 32'h8001_7FFF, 1'b0);
        chk("lh_last_cycle_no_to", to_cnt - t0, 32'd0);
        chk("lh_read_data", read_data, 32'hFFFF_8001);
        do_req(1'b0, 1'b0, 2'b01, 3'b101, 32'h0000_0102, 32'h0, 3, 32'h8001_7FFF, 1'b0);
        chk("lhu_read_data", read_data, 32'h0000_8001);
        do_req(1'b0, 1'b0, 2'b01, 3'b001, 32'h0000_0100, 32'h0, 1, 32'h7FFF_8000, 1'b0);
        chk("lh_low_read_data", read_data, 32'hFFFF_8000);

        // SB lane 1; SW via size 10 with read also high, pads raised during DONE
        do_req(1'b1, 1'b0, 2'b00, 3'b000, 32'h0000_0001, 32'h0000_00A7, 2, 32'h0, 1'b0);
        chk("sb_wdata", last_wd, 32'hA7A7_A7A7);
        chk("sb_be", {28'b0, last_be}, 32'h0000_0002);
        v0 = valid_cnt;
        do_req(1'b1, 1'b1, 2'b10, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 1, 32'h0, 1'b1);
        chk("sw_done_pads_ignored", valid_cnt - v0, 32'd1);
        chk("sw_wdata", last_wd, 32'hCAFE_F00D);

        // Unlisted funct3 behaves as LW
        do_req(1'b0, 1'b0, 2'b11, 3'b111, 32'h0000_0400, 32'h0, 1, 32'h0123_4567, 1'b0);
        chk("dt111_read_data", read_data, 32'h0123_4567);

        // Reset during REQUEST, with bus_ready arriving while reset is low
        rc = cyc;
        pad_read = 1'b1; pad_data_size = 2'b11; data_type = 3'b010; address = 32'h0000_0300;
        exp_stall[rc] = 1'b1;
        exp_stall[rc + 1] = 1'b1; exp_valid[rc + 1] = 1'b1; exp_wr[rc + 1] = 1'b0;
        exp_addr[rc + 1] = 32'h0000_0300; exp_be[rc + 1] = 4'hF; exp_wd[rc + 1] = 32'h0;
        for (int k = rc + 2; k < N; k++) exp_rd[k] = RST_RD;
        @(posedge clock); #1;
        pads_idle();
        @(posedge clock); #1;
        bus_if.bus_ready = 1'b1; bus_if.bus_read_data = 32'h1111_1111;
        #1 reset = 1'b0;
        #1;
        chk("rst_valid_drop", {31'b0, bus_if.bus_valid}, 32'd0);
        chk("rst_stall_drop", {31'b0, stall}, 32'd0);
        chk("rst_read_data", read_data, RST_RD);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        bus_if.bus_ready = 1'b0;
        @(posedge clock); #1;
        do_req(1'b0, 1'b0, 2'b11, 3'b010, 32'h0000_0500, 32'h0, 2, 32'h1357_9BDF, 1'b0);
        chk("post_rst_read_data", read_data, 32'h1357_9BDF);

        repeat (2) @(posedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/memory_bus_controller.md
Name: memory_bus_controller

Overview:
- Sits directly downstream of the operation controller's output interface (pad_read, pad_write, pad_data_size, data_type).
- Converts those per-phase pad strobes into a registered valid/ready transaction on the external memory bus, with byte strobes, write-lane replication and timeout.
- Returns load data to the core already aligned and sign/zero-extended.
- Asserts stall to freeze the phase sequencer while a bus transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: cycles REQUEST may wait for bus_ready before abort; counter width = clog2(TIMEOUT_CYCLES+1).
- RESET_READ_DATA, 32'h0: reset value of read_data.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- pad_read  in  1  core requests a read this cycle.
- pad_write  in  1  core requests a write this cycle; wins if pad_read is also high.
- pad_data_size  in  2  00 byte, 01 half, 11 word; 10 treated as word.
- data_type  in  3  funct3 of the load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others behave as LW.
- address  in  32  byte address.
- write_data  in  32  store data, low-aligned.
- read_data  out  32  aligned, extended load result.
- stall  out  1  core must hold its phase.
- misaligned  out  1  one-cycle pulse: request rejected, no bus cycle issued.
- bus_timeout  out  1  one-cycle pulse: transaction aborted.
- bus_valid  out  1  transaction presented.
- bus_write  out  1  1 = write, 0 = read.
- bus_address  out  32  word-aligned address, {address[31:2], 2'b00}.
- bus_byte_enable  out  4  lane strobes.
- bus_write_data  out  32  lane-replicated store data.
- bus_ready  in  1  slave accepts/completes the transaction this cycle.
- bus_read_data  in  32  valid when bus_valid & bus_ready & ~bus_write.

Behaviour:
- Reset (asynchronous, whenever reset==0): state IDLE; bus_valid, bus_write, stall, misaligned, bus_timeout = 0; bus_address, bus_byte_enable, bus_write_data = 0; read_data = RESET_READ_DATA; timeout counter = 0. Reset mid-transaction drops bus_valid immediately. No completion or pulse is produced.
- FSM states: IDLE, REQUEST, DONE.
- IDLE, no request: all strobes 0.
- IDLE, request (pad_read|pad_write):
  - Alignment check: half requires address[0]==0; word requires address[1:0]==0.
  - Misaligned: misaligned=1 the next cycle for exactly one cycle; no bus activity; stall stays 0; state stays IDLE.
  - Aligned: stall=1 combinationally in the same cycle. Latch bus_address, bus_write, strobes, write data and data_type/address[1:0]. Go to REQUEST.
- REQUEST:
  - bus_valid=1 and stall=1.
  - All bus outputs are held stable until handshake or timeout.
  - On bus_ready: capture the read result into read_data (reads only; writes leave it unchanged), clear the counter, go to DONE.
  - Otherwise the counter increments each cycle. When it equals TIMEOUT_CYCLES: bus_valid drops, bus_timeout pulses one cycle, read_data = 0 for reads, go to DONE.
- DONE: bus_valid=0, stall=0 for one cycle. Pad strobes are ignored in this cycle. Return to IDLE.
- Latency: an aligned request with bus_ready already high is 3 cycles, request cycle to stall release (IDLE → REQUEST → DONE).
- Byte strobes:
  - byte: 4'b0001 << address[1:0]
  - half: 4'b0011 << address[1:0]
  - word: 4'b1111
- Write replication:
  - byte: {4{write_data[7:0]}}
  - half: {2{write_data[15:0]}}
  - word: write_data unchanged.
- Read lane select: byte lane = bus_read_data >> (8*address[1:0]); half lane uses address[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- read_data holds its value until the next read completes or times out.
- Back-to-back requests are accepted only from IDLE, so the minimum spacing is 3 cycles.

Test Plan:
- Aligned LW: address 0x100, bus_ready high at the 2nd REQUEST cycle, bus_read_data 0xDEADBEEF → bus_byte_enable 1111, bus_address 0x100, read_data 0xDEADBEEF, stall high for exactly 3 cycles.
- LB at 0x103, data_type 000, bus_read_data 0x80FFFFFF → bus_byte_enable 1000, read_data 0xFFFFFF80. Repeat as LBU (100) → read_data 0x00000080.
- SH at 0x202, write_data 0x1234ABCD → bus_write=1, bus_byte_enable 1100, bus_write_data 0xABCDABCD, bus_address 0x200, read_data unchanged.
- LW at 0x101 → misaligned pulses 1 cycle, bus_valid never rises, stall stays 0. SH at 0x203 behaves the same.
- Read with bus_ready held low, TIMEOUT_CYCLES=4 → bus_valid high 4 cycles then drops, bus_timeout pulses once, read_data=0, stall released the following cycle.
- reset driven low during REQUEST (between clock edges) → bus_valid and stall drop immediately. After release, a fresh LW completes normally; bus_ready arriving during reset is ignored.
